interleaver_ctrl: RTL

INTERLEAVER_CTRL -- requirements
Module: interleaver_ctrl

---
 rtl/interleaver_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/interleaver_ctrl.sv
// interleaver_ctrl: gathers serial coded bits into Ncbps-sized blocks and hands them to the interleaver.
// A config load mid-block is parked as pending and takes effect once the block in progress completes.
module interleaver_ctrl #(
  parameter int MAX_BLK = 1152,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         cfg_mod,
  input  logic [2:0]         cfg_subch,
  input  logic               cfg_load,
  input  logic               in_bit,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [MAX_BLK-1:0] blk_data,
  output logic [10:0]        blk_size,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   blk_count
);
  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;
  state_t r_state, w_next;
  logic [MAX_BLK-1:0] r_data;
  logic [10:0] r_idx, r_cur, r_blk_size, r_pnd_size, w_new, w_ncpc;
  logic [CNT_W-1:0] r_count;
  logic r_pnd, r_pnd_bad, r_stop, r_err;
  logic w_ld_ok, w_ld_bad, w_acc, w_last, w_hs, w_imm, w_stop_n;
  always_comb begin
    w_ncpc   = cfg_mod == 2'd0 ? 11'd1 : cfg_mod == 2'd1 ? 11'd2 : cfg_mod == 2'd2 ? 11'd4 : 11'd6;
    w_new    = (11'd12 * w_ncpc) << cfg_subch;
    w_ld_ok  = cfg_load && cfg_subch <= 3'd4;
    w_ld_bad = cfg_load && cfg_subch > 3'd4;
    w_acc    = r_state == FILL && in_valid;
    w_last   = w_acc && r_idx == r_cur - 11'd1;
    w_hs     = r_state == HOLD && blk_ready;
    // an empty block may adopt a new config at once unless a bad load would strand a bit taken this cycle
    w_imm    = r_state == FILL && r_idx == 11'd0 && (w_ld_ok || !in_valid);
    w_stop_n = w_ld_ok ? 1'b0 : w_ld_bad ? 1'b1 : r_stop;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = w_ld_ok ? FILL : IDLE;
    else if (r_state == FILL) w_next = w_last ? HOLD : (w_imm && w_ld_bad) ? IDLE : FILL;
    else w_next = w_hs ? (w_stop_n ? IDLE : FILL) : HOLD;
  end
  always_comb begin
    in_ready  = r_state == FILL;
    blk_valid = r_state == HOLD;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_data     <= '0;
      r_idx      <= '0;
      r_cur      <= '0;
      r_blk_size <= '0;
      r_pnd_size <= '0;
      r_pnd      <= 1'b0;
      r_pnd_bad  <= 1'b0;
      r_stop     <= 1'b0;
      r_err      <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_acc) begin
        r_data[r_idx] <= in_bit;
        r_idx         <= w_last ? 11'd0 : r_idx + 11'd1;
      end
      if (w_last) r_blk_size <= r_cur;
      if (r_state == HOLD || w_last) begin
        if (w_ld_ok) begin
          r_cur  <= w_new;
          r_err  <= 1'b0;
          r_stop <= 1'b0;
        end else if (w_ld_bad) begin
          r_err  <= 1'b1;
          r_stop <= 1'b1;
        end else if (w_last && r_pnd) begin
          r_err  <= r_pnd_bad;
          r_stop <= r_pnd_bad;
          if (!r_pnd_bad) r_cur <= r_pnd_size;
        end
        if (w_last) r_pnd <= 1'b0;
      end else if (cfg_load) begin
        if (r_state == IDLE || w_imm) begin
          r_err  <= w_ld_bad;
          r_stop <= 1'b0;
          if (w_ld_ok) r_cur <= w_new;
        end else begin
          r_pnd      <= 1'b1;
          r_pnd_bad  <= w_ld_bad;
          r_pnd_size <= w_new;
          if (w_ld_bad) r_err <= 1'b1;
        end
      end
      if (w_hs) begin
        r_data  <= '0;
        r_count <= r_count + CNT_W'(1);
        r_stop  <= 1'b0;
      end
    end
  always_comb begin
    blk_data  = r_data;
    blk_size  = r_blk_size;
    cfg_err   = r_err;
    blk_count = r_count;
  end
endmodule
